// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared defines package for the execute stage: ALU operation/selection codes
// and the divider FSM state encodings and counter sizing.
// No ports (package).
// -----------------------------------------------------------------------------
package div_unit_pkg;

    // ALU operation codes
    localparam logic [7:0] ALUOP_NOP = 8'b0000_0000;
    localparam logic [7:0] ALUOP_DIV = 8'b0001_1010;
    localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

    // ALU result selection codes
    localparam logic [2:0] ALUSEL_NOP = 3'b000;
    localparam logic [2:0] ALUSEL_ARITH = 3'b100;

    // Divider FSM state encodings
    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } div_state_t;

    // Iteration counter width for a given operand width
    function automatic int div_cnt_width(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

    localparam int DIV_DATA_WIDTH = 32;
    localparam int DIV_CNT_WIDTH  = div_cnt_width(DIV_DATA_WIDTH);

endpackage

// File: rtl/div_abs.sv
// -----------------------------------------------------------------------------
// div_abs
// Conditional two's-complement negation: y = neg ? -a : a.
// Used both to take operand magnitudes and to re-apply result signs.
// Ports:
//   neg  in   1           negate when high
//   a    in   DATA_WIDTH  input value
//   y    out  DATA_WIDTH  result
// -----------------------------------------------------------------------------
module div_abs #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  neg,
    input  logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] y
);

    assign y = neg ? (~a + DATA_WIDTH'(1)) : a;

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle restoring divider with zero-divisor shortcut, cancel and a
// stall request for the pipeline controller.
// Optional feature: define DIV_SIGNED_EN to honour signed_in (signed
// division with magnitude conversion and result sign correction). Without it
// every operation is unsigned and signed_in is ignored.
// Ports:
//   clk          in   1           rising-edge clock
//   rst_n        in   1           async active-low reset
//   start        in   1           request, holds operands while high
//   cancel       in   1           abort, forces IDLE on the next edge
//   signed_in    in   1           1 = signed division
//   dividend     in   DATA_WIDTH  numerator
//   divisor      in   DATA_WIDTH  denominator
//   quotient     out  DATA_WIDTH  registered quotient
//   remainder    out  DATA_WIDTH  registered remainder
//   ready        out  1           result valid (END state)
//   busy         out  1           operation in flight
//   stall_req    out  1           busy and not ready
//   div_by_zero  out  1           current result came from a zero divisor
//
// State      | meaning
// DIV_IDLE   | waiting for start
// DIV_BYZERO | zero divisor: write fixed result, then go to END
// DIV_ON     | DATA_WIDTH shift-subtract steps, then result write-back
// DIV_END    | ready high, results held until start drops
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  cancel,
    input  logic                  signed_in,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  ready,
    output logic                  busy,
    output logic                  stall_req,
    output logic                  div_by_zero
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = div_cnt_width(W);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [2*W:0]     work;       // {partial remainder (W+1), quotient/dividend (W)}
    logic [W-1:0]     divisor_q;
    logic             wb_done;    // result registers written, END follows

    logic [W-1:0]     dividend_mag;
    logic [W-1:0]     divisor_mag;
    logic [W-1:0]     quot_fix;
    logic [W-1:0]     rem_fix;

    logic [2*W:0]     work_shift;
    logic [2*W:0]     work_step;
    logic [W:0]       trial;

`ifdef DIV_SIGNED_EN
    logic q_neg;
    logic r_neg;

    div_abs #(.DATA_WIDTH(W)) u_abs_dividend (
        .neg (signed_in & dividend[W-1]),
        .a   (dividend),
        .y   (dividend_mag)
    );

    div_abs #(.DATA_WIDTH(W)) u_abs_divisor (
        .neg (signed_in & divisor[W-1]),
        .a   (divisor),
        .y   (divisor_mag)
    );

    div_abs #(.DATA_WIDTH(W)) u_fix_quot (
        .neg (q_neg),
        .a   (work[W-1:0]),
        .y   (quot_fix)
    );

    // Remainder follows the dividend sign
    div_abs #(.DATA_WIDTH(W)) u_fix_rem (
        .neg (r_neg),
        .a   (work[2*W-1:W]),
        .y   (rem_fix)
    );
`else
    logic unused_signed_in;

    assign unused_signed_in = signed_in;
    assign dividend_mag     = dividend;
    assign divisor_mag      = divisor;
    assign quot_fix         = work[W-1:0];
    assign rem_fix          = work[2*W-1:W];
`endif

    // One restoring step: shift left, subtract divisor if it fits
    always_comb begin
        work_shift = work << 1;
        trial      = work_shift[2*W:W] - {1'b0, divisor_q};
        work_step  = work_shift;
        if (work_shift[2*W:W] >= {1'b0, divisor_q}) begin
            work_step[2*W:W] = trial;
            work_step[0]     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DIV_IDLE;
            cnt         <= '0;
            work        <= '0;
            divisor_q   <= '0;
            wb_done     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            stall_req   <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else if (cancel) begin
            // Results are deliberately left untouched
            state     <= DIV_IDLE;
            cnt       <= '0;
            wb_done   <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            stall_req <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        stall_req <= 1'b1;
                        wb_done   <= 1'b0;
                        if (divisor == '0) begin
                            state <= DIV_BYZERO;
                            work  <= {{(W+1){1'b0}}, dividend};
                        end else begin
                            state     <= DIV_ON;
                            cnt       <= CNT_W'(W);
                            divisor_q <= divisor_mag;
                            work      <= {{(W+1){1'b0}}, dividend_mag};
`ifdef DIV_SIGNED_EN
                            q_neg     <= signed_in & (dividend[W-1] ^ divisor[W-1]);
                            r_neg     <= signed_in & dividend[W-1];
`endif
                        end
                    end
                end
                DIV_BYZERO: begin
                    if (!wb_done) begin
                        quotient    <= '1;
                        remainder   <= work[W-1:0];
                        div_by_zero <= 1'b1;
                        wb_done     <= 1'b1;
                    end else begin
                        state     <= DIV_END;
                        ready     <= 1'b1;
                        stall_req <= 1'b0;
                    end
                end
                DIV_ON: begin
                    if (cnt != '0) begin
                        work <= work_step;
                        cnt  <= cnt - CNT_W'(1);
                    end else if (!wb_done) begin
                        quotient    <= quot_fix;
                        remainder   <= rem_fix;
                        div_by_zero <= 1'b0;
                        wb_done     <= 1'b1;
                    end else begin
                        state     <= DIV_END;
                        ready     <= 1'b1;
                        stall_req <= 1'b0;
                    end
                end
                DIV_END: begin
                    if (!start) begin
                        state     <= DIV_IDLE;
                        wb_done   <= 1'b0;
                        ready     <= 1'b0;
                        busy      <= 1'b0;
                        stall_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= DIV_IDLE;
                    ready     <= 1'b0;
                    busy      <= 1'b0;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
